// File: rtl/data_mem.sv
// Word-addressed 32-bit data memory, async active-low clear.
// Comb read (gated by re), registered write on Clk rising edge.
//
// Ports (positional order kept for legacy six-port instantiations):
//   Clk          : clock, all writes on its rising edge
//   Data_address : byte address, [AW+1:2] selects the word
//   Data_in      : write data
//   we           : write enable, active high
//   re           : read enable, active high
//   Data_out     : read data, 0 when re=0 or address out of range
//   Rst_n        : async active-low reset, clears every word
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        Clk,
  input  logic [31:0] Data_address,
  input  logic [31:0] Data_in,
  input  logic        we,
  input  logic        re,
  output logic [31:0] Data_out,
  input  logic        Rst_n
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_unused_lsb;

  assign w_idx        = Data_address[AW+1:2];
  assign w_in_range   = ~|Data_address[31:AW+2];
  // Byte offset is ignored: only word-aligned access.
  assign w_unused_lsb = ^Data_address[1:0];

  // An X/Z on we evaluates false in the if, so it never writes.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we && w_in_range) begin
      r_mem[w_idx] <= Data_in;
    end
  end

  always_comb begin
    Data_out = '0;
    if (re && w_in_range) begin
      Data_out = r_mem[w_idx];
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed literals + random
// traffic checked every cycle against an array model.
module tb_data_mem;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] din;
  logic        we;
  logic        re;
  logic [31:0] dout;

  int n_chk;
  int n_fail;

  logic [31:0] model [256];

  data_mem #(.DEPTH(256), .AW(8)) dut (
    .Clk         (clk),
    .Data_address(addr),
    .Data_in     (din),
    .we          (we),
    .re          (re),
    .Data_out    (dout),
    .Rst_n       (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic in_rng(input logic [31:0] a);
    return (a >> 10) == 32'd0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFF);
  endfunction

  function automatic logic [31:0] expect_out();
    if (re === 1'b1 && in_rng(addr))
      return model[widx(addr)];
    return 32'h0;
  endfunction

  // Reference model: reset wipes everything at once.
  always @(negedge rst_n) begin
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1 && we === 1'b1 && in_rng(addr))
      model[widx(addr)] = din;
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [31:0] e;
    e = expect_out();
    n_chk++;
    if (dout !== e) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t addr=%h: got %h expected %h",
               $time, addr, dout, e);
    end
  end

  task automatic chk(input string nm, input logic [31:0] e);
    n_chk++;
    if (dout !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, dout, e);
    end
  endtask

  task automatic drv(input logic [31:0] a, input logic [31:0] d,
                     input logic w, input logic r);
    addr = a;
    din  = d;
    we   = w;
    re   = r;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    rst_n = 1'b1;
    drv(32'h0, 32'h0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk("reset_idle", 32'h0);
    re = 1'b1;
    #1 chk("read_in_reset", 32'h0);
    re = 1'b0;
    #10 rst_n = 1'b1;
    repeat (4) step();
    chk("idle_after_reset", 32'h0);
    re = 1'b1;
    #1 chk("read_after_reset", 32'h0);

    drv(32'h0, 32'hFFFFFFFF, 1'b1, 1'b0);
    step();
    drv(32'h0, 32'h0, 1'b0, 1'b1);
    #1 chk("wr_rd_addr0", 32'hFFFFFFFF);
    re = 1'b0;
    #1 chk("re_low_zero", 32'h0);

    drv(32'h4, 32'hA5A5A5A5, 1'b1, 1'b0);
    step();
    drv(32'h8, 32'h12345678, 1'b1, 1'b0);
    step();
    drv(32'h4, 32'h0, 1'b0, 1'b1);
    #1 chk("rd_addr4", 32'hA5A5A5A5);
    addr = 32'h8;
    #1 chk("rd_addr8", 32'h12345678);
    addr = 32'h5;
    #1 chk("rd_addr5_alias", 32'hA5A5A5A5);
    addr = 32'h0;
    #1 chk("rd_addr0_kept", 32'hFFFFFFFF);

    drv(32'h400, 32'hDEADBEEF, 1'b1, 1'b1);
    #1 chk("oor_read_pre", 32'h0);
    step();
    we = 1'b0;
    #1 chk("oor_read_post", 32'h0);
    addr = 32'h0;
    #1 chk("oor_no_alias", 32'hFFFFFFFF);

    drv(32'h8, 32'hCAFEF00D, 1'b1, 1'b1);
    #1 chk("same_addr_old", 32'h12345678);
    step();
    chk("same_addr_new", 32'hCAFEF00D);

    drv(32'h4, 32'h11111111, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("midrst_addr4", 32'h0);
    addr = 32'h0;
    #1 chk("midrst_addr0", 32'h0);
    addr = 32'h4;
    repeat (2) step();
    chk("wr_held_in_rst", 32'h0);
    we = 1'b0;
    rst_n = 1'b1;
    step();
    chk("wr_dropped", 32'h0);
    addr = 32'h8;
    #1 chk("addr8_cleared", 32'h0);

    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0)
        a = a | (32'h1 << $urandom_range(10, 31));
      drv(a, $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      step();
    end

    drv(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words stored.
REQ-002 The block SHALL have parameter AW, default 8, meaning the word-index width (log2 DEPTH).

Interface
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes except reset occur on its rising edge.
REQ-004 The block SHALL have port Rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port Data_address, input, 32 bits: byte address.
REQ-006 The block SHALL have port Data_in, input, 32 bits: write data.
REQ-007 The block SHALL have port we, input, 1 bit: write enable, active high.
REQ-008 The block SHALL have port re, input, 1 bit: read enable, active high.
REQ-009 The block SHALL have port Data_out, output, 32 bits: read data.
REQ-010 Ports SHALL be declared in positional order Clk, Data_address, Data_in, we, re, Data_out, Rst_n, so existing six-port positional instantiations stay valid.

Function
REQ-011 Storage SHALL be DEPTH words of 32 bits, word-addressed.
REQ-012 Word index SHALL be Data_address[AW+1:2]; Data_address[1:0] SHALL be ignored (word-aligned access only).
REQ-013 An address SHALL be in range when Data_address[31:AW+2] is all zeros.
REQ-014 With we=1 and an in-range address, the block SHALL write Data_in to the indexed word at the Clk rising edge; latency 1 edge.
REQ-015 With we=1 and an out-of-range address, the block SHALL NOT modify any word.
REQ-016 With we=0, no word SHALL change.
REQ-017 Read SHALL be combinational, with zero latency: re=1 and an in-range address SHALL drive Data_out with the current contents of the indexed word.
REQ-018 Data_out SHALL be 32'h00000000 whenever re=0, or when re=1 with an out-of-range address.
REQ-019 With we=1 and re=1 on the same address, Data_out SHALL show the old word before the edge and Data_in after the edge.
REQ-020 we and re SHALL be independent; no handshake or busy signal exists.
REQ-021 X or Z on we SHALL NOT corrupt memory in simulation; only we==1 writes.

Reset
REQ-022 Rst_n=0 SHALL immediately clear all DEPTH words to 0, independent of Clk.
REQ-023 A write coinciding with asserted reset SHALL be discarded.
REQ-024 Data_out SHALL read 0 during and after reset until a word is written.
REQ-025 Reset asserted mid-operation SHALL override any pending write; normal operation SHALL resume on the first rising edge after Rst_n returns to 1.

Verification
REQ-026 Reset then idle: pulse Rst_n low; we=0, re=0, address 0 -> Data_out=0, and no word changes over several edges.
REQ-027 Read after reset: re=1, address 0 -> Data_out=32'h00000000.
REQ-028 Write/read: we=1, address 0, Data_in=32'hFFFFFFFF for one edge; then we=0, re=1, address 0 -> Data_out=32'hFFFFFFFF; with re=0 -> Data_out=0.
REQ-029 Addressing: write 32'hA5A5A5A5 at address 4 and 32'h12345678 at address 8 -> address 4 reads A5A5A5A5, address 8 reads 12345678, address 5 reads A5A5A5A5, address 0 is unchanged.
REQ-030 Out-of-range: we=1, address 32'h00000400, Data_in=32'hDEADBEEF -> that read returns 0, and address 0 is unchanged.
REQ-031 Mid-operation reset: after the writes above, assert Rst_n=0 between edges -> all reads return 0 immediately; a write held during reset does not persist.
